// File: rtl/dds_sweep_sequencer.sv
// DDS frequency sweep sequencer: steps a phase increment from start to stop,
// holding each point valid for a fixed time, then dwelling before the next.
module dds_sweep_sequencer #(
    parameter int PHASE_INC_WIDTH = 27,
    parameter int VALID_CYCLES    = 16,
    parameter int DWELL_WIDTH     = 24
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic [PHASE_INC_WIDTH-1:0] cfg_start_inc,
    input  logic [PHASE_INC_WIDTH-1:0] cfg_stop_inc,
    input  logic [PHASE_INC_WIDTH-1:0] cfg_step,
    input  logic [DWELL_WIDTH-1:0]     cfg_dwell,
    input  logic                       cfg_up,
    input  logic                       start,
    input  logic                       abort,
    output logic [PHASE_INC_WIDTH-1:0] phase_inc,
    output logic                       phase_inc_valid,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                point_count
);

    localparam int W   = PHASE_INC_WIDTH;
    localparam int HCW = $clog2(VALID_CYCLES + 1);

    localparam logic [W-1:0]   RESET_INC = W'(8388608);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(VALID_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        DWELL,
        STEP
    } state_t;

    state_t state, state_n;

    logic [W-1:0]           sh_stop, sh_stop_n;
    logic [W-1:0]           sh_step, sh_step_n;
    logic [DWELL_WIDTH-1:0] sh_dwell, sh_dwell_n;
    logic                   sh_up, sh_up_n;
    logic                   sh_degen, sh_degen_n;
    logic [W-1:0]           cur, cur_n;
    logic [W-1:0]           phase_n;
    logic                   valid_n;
    logic                   done_n;
    logic [15:0]            count_n;
    logic [HCW-1:0]         hold_cnt, hold_cnt_n;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_n;

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] next_up;
    logic [W-1:0] next_dn;

    assign busy = (state != IDLE);

    // Candidate next point in both directions, clamped to the stop value
    always_comb begin
        sum  = {1'b0, cur} + {1'b0, sh_step};
        diff = {1'b0, cur} - {1'b0, sh_step};
        if (sum[W] || (sum[W-1:0] >= sh_stop)) begin
            next_up = sh_stop;
        end else begin
            next_up = sum[W-1:0];
        end
        if (diff[W] || (diff[W-1:0] <= sh_stop)) begin
            next_dn = sh_stop;
        end else begin
            next_dn = diff[W-1:0];
        end
    end

    // Next-state and next-output logic; abort overrides every busy state
    always_comb begin
        state_n     = state;
        sh_stop_n   = sh_stop;
        sh_step_n   = sh_step;
        sh_dwell_n  = sh_dwell;
        sh_up_n     = sh_up;
        sh_degen_n  = sh_degen;
        cur_n       = cur;
        phase_n     = phase_inc;
        valid_n     = phase_inc_valid;
        done_n      = 1'b0;
        count_n     = point_count;
        hold_cnt_n  = hold_cnt;
        dwell_cnt_n = dwell_cnt;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    sh_stop_n  = cfg_stop_inc;
                    sh_step_n  = cfg_step;
                    sh_dwell_n = cfg_dwell;
                    sh_up_n    = cfg_up;
                    sh_degen_n = (cfg_step == '0) ||
                                 (cfg_up  && (cfg_start_inc > cfg_stop_inc)) ||
                                 (!cfg_up && (cfg_start_inc < cfg_stop_inc));
                    cur_n      = cfg_start_inc;
                    count_n    = '0;
                    state_n    = LOAD;
                end
            end
            LOAD: begin
                phase_n    = cur;
                valid_n    = 1'b1;
                hold_cnt_n = '0;
                if (point_count != 16'hFFFF) begin
                    count_n = point_count + 16'd1;
                end
                state_n = HOLD;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    valid_n     = 1'b0;
                    dwell_cnt_n = '0;
                    state_n     = (sh_dwell == '0) ? STEP : DWELL;
                end else begin
                    hold_cnt_n = hold_cnt + HCW'(1);
                end
            end
            DWELL: begin
                if (dwell_cnt == (sh_dwell - DWELL_WIDTH'(1))) begin
                    state_n = STEP;
                end else begin
                    dwell_cnt_n = dwell_cnt + DWELL_WIDTH'(1);
                end
            end
            STEP: begin
                if ((cur == sh_stop) || sh_degen) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cur_n   = sh_up ? next_up : next_dn;
                    state_n = LOAD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b0;
            phase_n = phase_inc;
            count_n = point_count;
        end
    end

    // State, shadow configuration, counters and registered outputs
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sh_stop         <= '0;
            sh_step         <= '0;
            sh_dwell        <= '0;
            sh_up           <= 1'b0;
            sh_degen        <= 1'b0;
            cur             <= '0;
            phase_inc       <= RESET_INC;
            phase_inc_valid <= 1'b0;
            done            <= 1'b0;
            point_count     <= '0;
            hold_cnt        <= '0;
            dwell_cnt       <= '0;
        end else begin
            state           <= state_n;
            sh_stop         <= sh_stop_n;
            sh_step         <= sh_step_n;
            sh_dwell        <= sh_dwell_n;
            sh_up           <= sh_up_n;
            sh_degen        <= sh_degen_n;
            cur             <= cur_n;
            phase_inc       <= phase_n;
            phase_inc_valid <= valid_n;
            done            <= done_n;
            point_count     <= count_n;
            hold_cnt        <= hold_cnt_n;
            dwell_cnt       <= dwell_cnt_n;
        end
    end

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Directed bench for dds_sweep_sequencer: ascending, clamped, overflow,
// degenerate, abort and mid-sweep reset scenarios.
module tb_dds_sweep_sequencer;

    logic        aclk = 1'b0;
    logic        reset;
    logic [26:0] cfg_start_inc;
    logic [26:0] cfg_stop_inc;
    logic [26:0] cfg_step;
    logic [23:0] cfg_dwell;
    logic        cfg_up;
    logic        start;
    logic        abort;
    logic [26:0] phase_inc;
    logic        phase_inc_valid;
    logic        busy;
    logic        done;
    logic [15:0] point_count;

    int checks = 0;
    int errors = 0;

    logic [26:0] pts[$];
    int          runs[$];
    int          gaps[$];
    int          done_cnt = 0;
    int          stable_err = 0;
    int          run_len = 0;
    int          low_len = 0;
    logic        pv = 1'b0;

    dds_sweep_sequencer dut (
        .aclk            (aclk),
        .reset           (reset),
        .cfg_start_inc   (cfg_start_inc),
        .cfg_stop_inc    (cfg_stop_inc),
        .cfg_step        (cfg_step),
        .cfg_dwell       (cfg_dwell),
        .cfg_up          (cfg_up),
        .start           (start),
        .abort           (abort),
        .phase_inc       (phase_inc),
        .phase_inc_valid (phase_inc_valid),
        .busy            (busy),
        .done            (done),
        .point_count     (point_count)
    );

    always #5 aclk = ~aclk;

    // Record emitted points, valid run lengths, gaps and done pulses
    always @(negedge aclk) begin
        if (reset) begin
            pv      = 1'b0;
            run_len = 0;
            low_len = 0;
        end else begin
            if (phase_inc_valid) begin
                if (!pv) begin
                    if (pts.size() > 0) gaps.push_back(low_len);
                    pts.push_back(phase_inc);
                    run_len = 0;
                end else if (phase_inc != pts[$]) begin
                    stable_err++;
                end
                run_len++;
                low_len = 0;
            end else begin
                if (pv) runs.push_back(run_len);
                low_len++;
            end
            if (done) done_cnt++;
            pv = phase_inc_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic begin_sweep(input string tag, input logic [26:0] s,
                               input logic [26:0] e, input logic [26:0] st,
                               input logic [23:0] d, input logic up);
        @(negedge aclk);
        pts.delete();
        runs.delete();
        gaps.delete();
        done_cnt   = 0;
        stable_err = 0;
        cfg_start_inc = s;
        cfg_stop_inc  = e;
        cfg_step      = st;
        cfg_dwell     = d;
        cfg_up        = up;
        start         = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        check({tag, "_lat_v0"}, 32'(phase_inc_valid), 32'd0);
        @(negedge aclk);
        check({tag, "_lat_v1"}, 32'(phase_inc_valid), 32'd1);
        check({tag, "_lat_p"}, 32'(phase_inc), 32'(s));
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 2000) begin
            @(negedge aclk);
            k++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
        @(negedge aclk);
    endtask

    task automatic check_pts(input string tag, input int n,
                             input logic [26:0] e0, input logic [26:0] e1,
                             input logic [26:0] e2, input logic [26:0] e3,
                             input int gap);
        logic [26:0] ev[4];
        ev[0] = e0;
        ev[1] = e1;
        ev[2] = e2;
        ev[3] = e3;
        check({tag, "_npts"}, 32'(pts.size()), 32'(n));
        for (int i = 0; i < n && i < 4; i++) begin
            if (i < pts.size()) begin
                check($sformatf("%s_p%0d", tag, i), 32'(pts[i]), 32'(ev[i]));
            end
        end
        check({tag, "_nruns"}, 32'(runs.size()), 32'(n));
        for (int i = 0; i < runs.size(); i++) begin
            check($sformatf("%s_run%0d", tag, i), 32'(runs[i]), 32'd16);
        end
        if (gaps.size() > 0) check({tag, "_gap"}, 32'(gaps[0]), 32'(gap));
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_cnt"}, 32'(point_count), 32'(n));
        check({tag, "_stable"}, 32'(stable_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        cfg_start_inc = '0;
        cfg_stop_inc  = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_up        = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_phase", 32'(phase_inc), 32'd8388608);
        check("rst_valid", 32'(phase_inc_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(point_count), 32'd0);
        reset = 1'b0;

        // abort and start together in IDLE: nothing starts
        @(negedge aclk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins", 32'(busy), 32'd0);

        // ascending: DWELL state lasts 4 cycles, plus STEP and LOAD
        begin_sweep("asc", 27'd1000, 27'd1300, 27'd100, 24'd4, 1'b1);
        wait_idle("asc");
        check_pts("asc", 4, 27'd1000, 27'd1100, 27'd1200, 27'd1300, 6);

        begin_sweep("clup", 27'd0, 27'd250, 27'd100, 24'd0, 1'b1);
        wait_idle("clup");
        check_pts("clup", 4, 27'd0, 27'd100, 27'd200, 27'd250, 2);

        begin_sweep("cldn", 27'd250, 27'd0, 27'd100, 24'd1, 1'b0);
        wait_idle("cldn");
        check_pts("cldn", 4, 27'd250, 27'd150, 27'd50, 27'd0, 3);

        begin_sweep("ovf", 27'h7FFFF00, 27'h7FFFFFF, 27'h200, 24'd2, 1'b1);
        wait_idle("ovf");
        check_pts("ovf", 2, 27'h7FFFF00, 27'h7FFFFFF, 27'd0, 27'd0, 4);

        begin_sweep("step0", 27'd500, 27'd900, 27'd0, 24'd3, 1'b1);
        wait_idle("step0");
        check_pts("step0", 1, 27'd500, 27'd0, 27'd0, 27'd0, 0);

        begin_sweep("dirmm", 27'd500, 27'd100, 27'd100, 24'd3, 1'b1);
        wait_idle("dirmm");
        check_pts("dirmm", 1, 27'd500, 27'd0, 27'd0, 27'd0, 0);

        // abort in HOLD of second point; a start while busy is ignored
        begin_sweep("abt", 27'd1000, 27'd1300, 27'd100, 24'd4, 1'b1);
        @(negedge aclk);
        cfg_start_inc = 27'd5;
        cfg_step      = 27'd7;
        start         = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int k = 0; k < 200 && pts.size() < 2; k++) @(negedge aclk);
        check("abt_reach2", 32'(pts.size()), 32'd2);
        repeat (3) @(negedge aclk);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        check("abt_valid", 32'(phase_inc_valid), 32'd0);
        check("abt_busy", 32'(busy), 32'd0);
        check("abt_phase", 32'(phase_inc), 32'd1100);
        check("abt_done", 32'(done), 32'd0);
        check("abt_cnt", 32'(point_count), 32'd2);
        repeat (4) @(negedge aclk);
        check("abt_nodone", 32'(done_cnt), 32'd0);
        check("abt_idle", 32'(busy), 32'd0);

        // reset during DWELL after the first point
        begin_sweep("rstm", 27'd1000, 27'd1300, 27'd100, 24'd4, 1'b1);
        for (int k = 0; k < 100 && runs.size() < 1; k++) @(negedge aclk);
        @(negedge aclk);
        reset = 1'b1;
        #1;
        check("rstm_phase", 32'(phase_inc), 32'd8388608);
        check("rstm_valid", 32'(phase_inc_valid), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_done", 32'(done), 32'd0);
        check("rstm_cnt", 32'(point_count), 32'd0);
        @(negedge aclk);
        reset = 1'b0;
        repeat (3) @(negedge aclk);
        check("rstm_wait", 32'(busy), 32'd0);
        check("rstm_nodone", 32'(done_cnt), 32'd0);

        begin_sweep("post", 27'd1000, 27'd1300, 27'd100, 24'd4, 1'b1);
        wait_idle("post");
        check_pts("post", 4, 27'd1000, 27'd1100, 27'd1200, 27'd1300, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
